// File: rtl/merge_pkg.sv
// merge_pkg: shared definitions for the lane-merge receive path.
//   state_e - collect/hold states of the word assembler
//   BEAT_W  - bits carried per lane beat
//   decross - undoes the lane crossing applied by the splitter
package merge_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    localparam int BEAT_W = 2;

    // The link swaps the two lanes: lane 0 carries beat bit 1 and
    // lane 1 carries beat bit 0. Swapping back restores the beat.
    function automatic logic [BEAT_W-1:0] decross(input logic [BEAT_W-1:0] lane);
        return {lane[0], lane[1]};
    endfunction

endpackage

// File: rtl/merge_if.sv
// merge_if: beat input stream and word output stream of the merge block.
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high; the sender holds its payload stable
// while valid is high and ready is low.
//   in_valid/in_lane/in_last/in_ready     - crossed two-lane beat stream
//   out_valid/out_data/out_short/out_ready - assembled word stream
// Modports: slave = the merge block, master = the surrounding environment.
interface merge_if #(
    parameter int WORD_BEATS = 4
);
    localparam int W = 2 * WORD_BEATS;

    logic           in_valid;
    logic [1:0]     in_lane;
    logic           in_last;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_short;
    logic           out_ready;

    modport slave (
        input  in_valid, in_lane, in_last, out_ready,
        output in_ready, out_valid, out_data, out_short
    );

    modport master (
        output in_valid, in_lane, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_short
    );

endinterface

// File: rtl/merge_sat_cnt.sv
// merge_sat_cnt: event counter that stops at all-ones instead of wrapping.
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears the count
//   en    - count one event this cycle
//   count - current count
module merge_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/merge.sv
// merge: de-crosses a stream of 2-bit lane beats and packs WORD_BEATS beats
// (beat 0 in the low bits) into one word, presented on a valid/ready output.
// A word closes early when in_last arrives before the final beat; such a
// word has its unfilled upper bits at zero and out_short set.
//   clk         - clock
//   rst_n       - asynchronous active-low reset
//   bus         - merge_if slave: beat input and word output streams
//   word_cnt    - saturating count of delivered words
//   o_dbg_state - current assembler state
module merge
    import merge_pkg::*;
#(
    parameter int WORD_BEATS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    merge_if.slave           bus,
    output logic [CNT_W-1:0] word_cnt,
    output state_e           o_dbg_state
);

    localparam int W     = BEAT_W * WORD_BEATS;
    localparam int IDX_W = $clog2(WORD_BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BEATS - 1);

    state_e            r_state;
    state_e            w_next_state;
    logic [IDX_W-1:0]  r_idx;
    logic [W-1:0]      r_data;
    logic              r_short;

    logic              w_accept;
    logic              w_close;
    logic              w_deliver;
    logic [BEAT_W-1:0] w_beat;

    // Beats are only taken while collecting, so the two handshakes can
    // never both fire in one cycle.
    assign w_accept  = bus.in_valid && (r_state == COLLECT);
    assign w_close   = w_accept && (bus.in_last || (r_idx == LAST_IDX));
    assign w_deliver = (r_state == HOLD) && bus.out_ready;
    assign w_beat    = decross(bus.in_lane);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            COLLECT: if (w_close)   w_next_state = HOLD;
            HOLD:    if (w_deliver) w_next_state = COLLECT;
            default:                w_next_state = COLLECT;
        endcase
    end

    // The assembly register is cleared on delivery, so a word closed early
    // by in_last naturally carries zeros above its last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_data  <= '0;
            r_short <= 1'b0;
        end else if (w_deliver) begin
            r_data  <= '0;
            r_short <= 1'b0;
        end else if (w_accept) begin
            for (int k = 0; k < WORD_BEATS; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    r_data[BEAT_W*k +: BEAT_W] <= w_beat;
                end
            end
            if (w_close) begin
                r_idx   <= '0;
                // in_last on the final beat still makes a full word
                r_short <= (r_idx != LAST_IDX);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    merge_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_deliver),
        .count (word_cnt)
    );

    assign bus.in_ready  = (r_state == COLLECT);
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_data  = r_data;
    assign bus.out_short = r_short;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_merge.sv
// tb_merge: directed bench for merge (WORD_BEATS=4) plus a second instance
// with a 3-bit word counter for the saturation case.
module tb_merge;
    import merge_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic mon_en;

    logic [7:0] exp_q[$];

    merge_if #(.WORD_BEATS(4)) bus  ();
    merge_if #(.WORD_BEATS(4)) bus2 ();

    logic [15:0] word_cnt;
    logic [2:0]  word_cnt2;
    state_e      dbg_state;
    state_e      dbg_state2;

    merge #(.WORD_BEATS(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .word_cnt    (word_cnt),
        .o_dbg_state (dbg_state)
    );

    merge #(.WORD_BEATS(4), .CNT_W(3)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus2.slave),
        .word_cnt    (word_cnt2),
        .o_dbg_state (dbg_state2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference lane swap: lane 0 holds beat bit 1, lane 1 holds beat bit 0.
    function automatic logic [1:0] ref_beat(input logic [1:0] lane);
        logic [1:0] b;
        b[1] = lane[0];
        b[0] = lane[1];
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one beat from a falling edge and return right after the rising
    // edge that takes it. in_valid is left high for back-to-back use.
    task automatic beat(input logic [1:0] lane, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_lane  = lane;
        bus.in_last  = last;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $error("FAIL beat_timeout observed=in_ready_low expected=in_ready_high");
        end
        @(posedge clk);
    endtask

    // Word has just closed and out_ready is high: check the HOLD cycle and
    // the cycle after delivery.
    task automatic deliver(input string tag, input logic [7:0] data, input logic shrt,
                           input logic [15:0] cnt);
        @(negedge clk);
        check({tag, "_valid"},    32'(bus.out_valid), 32'd1);
        check({tag, "_data"},     32'(bus.out_data),  32'(data));
        check({tag, "_short"},    32'(bus.out_short), 32'(shrt));
        check({tag, "_in_ready"}, 32'(bus.in_ready),  32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_cnt"},        32'(word_cnt),      32'(cnt));
    endtask

    // scoreboard for the random section
    always @(negedge clk) begin
        if (mon_en && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("sb_data",  32'(bus.out_data),  32'(e));
                check("sb_short", 32'(bus.out_short), 32'd0);
            end
        end
    end

    initial begin
        logic [7:0] exp_w;
        logic [1:0] lane;
        int         g;
        int         n;

        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        bus.in_valid  = 1'b0; bus.in_lane  = 2'b00; bus.in_last  = 1'b0; bus.out_ready  = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_lane = 2'b00; bus2.in_last = 1'b0; bus2.out_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_state",    32'(dbg_state),     32'(COLLECT));
        check("rst_in_ready", 32'(bus.in_ready),  32'd1);
        check("rst_valid",    32'(bus.out_valid), 32'd0);
        check("rst_data",     32'(bus.out_data),  32'd0);
        check("rst_short",    32'(bus.out_short), 32'd0);
        check("rst_cnt",      32'(word_cnt),      32'd0);
        rst_n = 1'b1;

        // full word back-to-back: beats 2,1,3,0 -> 0x36
        bus.out_ready = 1'b1;
        beat(2'b01, 1'b0); beat(2'b10, 1'b0); beat(2'b11, 1'b0); beat(2'b00, 1'b0);
        deliver("w1", 8'h36, 1'b0, 16'd1);

        // short word: beats 3,1 -> 0x07
        beat(2'b11, 1'b0); beat(2'b10, 1'b1);
        deliver("short", 8'h07, 1'b1, 16'd2);

        // full word after a short one: beat 3 = 2 -> 0x80
        beat(2'b00, 1'b0); beat(2'b00, 1'b0); beat(2'b00, 1'b0); beat(2'b01, 1'b0);
        deliver("after_short", 8'h80, 1'b0, 16'd3);

        // stall: in_last on the final beat, beats 3,1,2,0 -> 0x27, held 5 cycles
        bus.out_ready = 1'b0;
        beat(2'b11, 1'b0); beat(2'b10, 1'b0); beat(2'b01, 1'b0); beat(2'b00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_lane  = 2'b01;
            bus.in_last  = 1'b1;
            check("stall_valid",    32'(bus.out_valid), 32'd1);
            check("stall_in_ready", 32'(bus.in_ready),  32'd0);
            check("stall_data",     32'(bus.out_data),  32'h27);
            check("stall_short",    32'(bus.out_short), 32'd0);
            check("stall_cnt",      32'(word_cnt),      32'd3);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_valid", 32'(bus.out_valid), 32'd0);
        check("stall_release_cnt",   32'(word_cnt),      32'd4);
        bus.in_valid = 1'b0;
        // a stale beat taken during the stall would misalign this word
        beat(2'b01, 1'b0); beat(2'b01, 1'b0); beat(2'b01, 1'b0); beat(2'b01, 1'b0);
        deliver("post_stall", 8'hAA, 1'b0, 16'd5);

        // asynchronous reset in the middle of a word
        beat(2'b01, 1'b0); beat(2'b01, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_state",    32'(dbg_state),     32'(COLLECT));
        check("async_in_ready", 32'(bus.in_ready),  32'd1);
        check("async_valid",    32'(bus.out_valid), 32'd0);
        check("async_data",     32'(bus.out_data),  32'd0);
        check("async_cnt",      32'(word_cnt),      32'd0);
        #1 rst_n = 1'b1;
        beat(2'b11, 1'b0); beat(2'b11, 1'b0); beat(2'b11, 1'b0); beat(2'b11, 1'b0);
        deliver("after_rst", 8'hFF, 1'b0, 16'd1);

        // 3-bit counter saturation: nine one-beat words
        bus2.out_ready = 1'b1;
        for (int w = 0; w < 9; w++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1;
            bus2.in_lane  = 2'b10;
            bus2.in_last  = 1'b1;
            @(negedge clk);
            check("sat_valid", 32'(bus2.out_valid), 32'd1);
            check("sat_data",  32'(bus2.out_data),  32'h01);
            check("sat_short", 32'(bus2.out_short), 32'd1);
            bus2.in_valid = 1'b0;
            @(negedge clk);
            check("sat_cnt", 32'(word_cnt2), (w + 1 > 7) ? 32'd7 : 32'(w + 1));
        end

        // random gaps, 100 full words against the scoreboard
        mon_en = 1'b1;
        for (int w = 0; w < 100; w++) begin
            exp_w = 8'h00;
            for (int k = 0; k < 4; k++) begin
                g = 0;
                while ($urandom_range(0, 1) == 1 && g < 6) begin
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                    bus.in_lane  = 2'($urandom_range(0, 3));
                    bus.in_last  = 1'($urandom_range(0, 1));
                    g++;
                end
                lane = 2'($urandom_range(0, 3));
                exp_w[2*k +: 2] = ref_beat(lane);
                beat(lane, 1'b0);
            end
            exp_q.push_back(exp_w);
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        @(negedge clk);
        check("rand_cnt", 32'(word_cnt), 32'd101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
